// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and the initiator FSM state encoding.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } axi4lite_mst_state_e;

endpackage

// File: rtl/axi4lite_master_adapter_if.sv
// AXI4-Lite bus bundle; master drives AW/W/AR plus bready/rready, slave drives the rest.
interface axi4lite_master_adapter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4lite_master_adapter.sv
// Single-outstanding AXI4-Lite initiator: valid/ready command in, one AXI read or write, response out.
// Latency: AXI valids one cycle after command accept; response one cycle after B/R handshake.
module axi4lite_master_adapter
   import axi4lite_pkg::*;
#(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter int         LAT_WIDTH  = 8,
   parameter logic [2:0] AXI_PROT   = 3'b000
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_we,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [LAT_WIDTH-1:0]    rsp_lat,
   output logic                    busy,
   axi4lite_master_adapter_if.master m_axi
);

   axi4lite_mst_state_e     state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
   logic                    aw_done_q, w_done_q;
   logic [LAT_WIDTH-1:0]    lat_q;
   logic                    rsp_valid_q, rsp_we_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]              rsp_resp_q;
   logic [LAT_WIDTH-1:0]    rsp_lat_q;

   logic                    aw_hs, w_hs;
   logic [LAT_WIDTH-1:0]    lat_inc;

   assign aw_hs   = awvalid_q && m_axi.awready;
   assign w_hs    = wvalid_q && m_axi.wready;
   assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_WIDTH'(1);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         lat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_lat_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  // The first valid cycle is already counted, so a zero-wait access reports 2.
                  lat_q   <= LAT_WIDTH'(1);
                  if (cmd_we) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= ST_WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR: begin
               lat_q <= lat_inc;
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (m_axi.bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_we_q    <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= m_axi.bresp;
                  rsp_lat_q   <= lat_q;
                  state_q     <= ST_RSP;
               end else begin
                  lat_q <= lat_inc;
               end
            end
            ST_RD_ADDR: begin
               lat_q <= lat_inc;
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (m_axi.rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_we_q    <= 1'b0;
                  rsp_rdata_q <= m_axi.rdata;
                  rsp_resp_q  <= m_axi.rresp;
                  rsp_lat_q   <= lat_q;
                  state_q     <= ST_RSP;
               end else begin
                  lat_q <= lat_inc;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE) && !areset;
   assign busy          = (state_q != ST_IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_we        = rsp_we_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_lat       = rsp_lat_q;

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = AXI_PROT;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = AXI_PROT;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_adapter.sv
// Randomized bench for axi4lite_master_adapter with a delay-programmable AXI slave and a
// transaction-level expectation (latency from handshake-delay arithmetic).
module tb_axi4lite_master_adapter;
   import axi4lite_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int LAT_MAX = (1 << LW) - 1;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_we, busy;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [LW-1:0] rsp_lat;

   always #5 aclk = ~aclk;

   axi4lite_master_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi4lite_master_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW), .AXI_PROT(3'b000)) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_lat(rsp_lat), .busy(busy),
      .m_axi(axi)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    wstrb;
      int            daw, dw, db, dar, dr;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } txn_t;

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave programming for the transaction in flight, and what the bus monitor saw.
   int            d_aw, d_w, d_b, d_ar, d_r;
   logic [1:0]    s_resp;
   logic [DW-1:0] s_rdata;
   logic [AW-1:0] cap_awaddr, cap_araddr;
   logic [DW-1:0] cap_wdata;
   logic [3:0]    cap_wstrb;
   int            n_aw, n_w, n_b, n_ar, n_r, cyc_awv, cyc_wv, cyc_arv, viol;

   initial begin
      bit ok;
      axi.awready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!areset && axi.awvalid) begin
            ok = 1'b1;
            for (int i = 0; i < d_aw; i++) begin @(negedge aclk); if (areset) begin ok = 1'b0; break; end end
            if (ok) begin cap_awaddr = axi.awaddr; axi.awready = 1'b1; @(negedge aclk); axi.awready = 1'b0; end
         end
      end
   end

   initial begin
      bit ok;
      axi.wready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!areset && axi.wvalid) begin
            ok = 1'b1;
            for (int i = 0; i < d_w; i++) begin @(negedge aclk); if (areset) begin ok = 1'b0; break; end end
            if (ok) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; axi.wready = 1'b1; @(negedge aclk); axi.wready = 1'b0; end
         end
      end
   end

   initial begin
      bit ok;
      axi.bvalid = 1'b0; axi.bresp = '0;
      forever begin
         @(negedge aclk);
         if (!areset && axi.bready) begin
            ok = 1'b1;
            for (int i = 0; i < d_b; i++) begin @(negedge aclk); if (areset) begin ok = 1'b0; break; end end
            if (ok) begin axi.bresp = s_resp; axi.bvalid = 1'b1; @(negedge aclk); axi.bvalid = 1'b0; axi.bresp = '0; end
         end
      end
   end

   initial begin
      bit ok;
      axi.arready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!areset && axi.arvalid) begin
            ok = 1'b1;
            for (int i = 0; i < d_ar; i++) begin @(negedge aclk); if (areset) begin ok = 1'b0; break; end end
            if (ok) begin cap_araddr = axi.araddr; axi.arready = 1'b1; @(negedge aclk); axi.arready = 1'b0; end
         end
      end
   end

   initial begin
      bit ok;
      axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
      forever begin
         @(negedge aclk);
         if (!areset && axi.rready) begin
            ok = 1'b1;
            for (int i = 0; i < d_r; i++) begin @(negedge aclk); if (areset) begin ok = 1'b0; break; end end
            if (ok) begin
               axi.rdata = s_rdata; axi.rresp = s_resp; axi.rvalid = 1'b1;
               @(negedge aclk);
               axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
            end
         end
      end
   end

   // Bus monitor: handshake/valid-cycle counts and protocol rule violations.
   initial begin
      bit pend_aw = 0, pend_w = 0, pend_ar = 0;
      logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
      logic [DW-1:0] p_wdata = '0;
      logic [3:0]    p_wstrb = '0;
      forever begin
         @(negedge aclk); #1;
         if (areset) begin
            pend_aw = 0; pend_w = 0; pend_ar = 0;
         end else begin
            if (axi.awvalid) cyc_awv++;
            if (axi.wvalid)  cyc_wv++;
            if (axi.arvalid) cyc_arv++;
            if (axi.awvalid && axi.awready) n_aw++;
            if (axi.wvalid && axi.wready)   n_w++;
            if (axi.bvalid && axi.bready)   n_b++;
            if (axi.arvalid && axi.arready) n_ar++;
            if (axi.rvalid && axi.rready)   n_r++;
            if (pend_aw && (!axi.awvalid || axi.awaddr != p_awaddr)) viol++;
            if (pend_w && (!axi.wvalid || axi.wdata != p_wdata || axi.wstrb != p_wstrb)) viol++;
            if (pend_ar && (!axi.arvalid || axi.araddr != p_araddr)) viol++;
            if (axi.bready && (axi.awvalid || axi.wvalid || axi.arvalid || axi.rready)) viol++;
            if (axi.rready && (axi.arvalid || axi.awvalid || axi.wvalid)) viol++;
            pend_aw = axi.awvalid && !axi.awready; p_awaddr = axi.awaddr;
            pend_w  = axi.wvalid && !axi.wready;   p_wdata = axi.wdata; p_wstrb = axi.wstrb;
            pend_ar = axi.arvalid && !axi.arready; p_araddr = axi.araddr;
         end
      end
   end

   function automatic int exp_lat(input txn_t t);
      int l;
      if (t.we) l = ((t.daw > t.dw) ? t.daw : t.dw) + 2 + t.db;
      else      l = t.dar + t.dr + 2;
      return (l > LAT_MAX) ? LAT_MAX : l;
   endfunction

   function automatic txn_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [3:0] wstrb, input int daw, input int dw, input int db,
                               input int dar, input int dr, input logic [1:0] resp, input logic [DW-1:0] rdata);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      t.daw = daw; t.dw = dw; t.db = db; t.dar = dar; t.dr = dr; t.resp = resp; t.rdata = rdata;
      return t;
   endfunction

   function automatic txn_t gen();
      int slow;
      slow = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 3);
      return mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 4), $urandom_range(0, 4), slow, $urandom_range(0, 4), slow,
                2'($urandom_range(0, 3)), $urandom);
   endfunction

   // Called at a negedge; returns at the negedge after the command handshake.
   task automatic issue(input txn_t t);
      int k;
      d_aw = t.daw; d_w = t.dw; d_b = t.db; d_ar = t.dar; d_r = t.dr;
      s_resp = t.resp; s_rdata = t.rdata;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; cyc_awv = 0; cyc_wv = 0; cyc_arv = 0;
      cmd_we = t.we; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_wstrb = t.wstrb; cmd_valid = 1'b1;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 100) begin @(negedge aclk); k++; end
      check("cmd_ready_wait", cmd_ready, 1'b1);
      @(negedge aclk);
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input txn_t t, input int hold, input bit bb, input txn_t nxt);
      int k;
      logic [DW-1:0] exp_rd;
      exp_rd = t.we ? '0 : t.rdata;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 200) begin @(negedge aclk); k++; end
      check("rsp_valid_wait", rsp_valid, 1'b1);
      if (bb) begin
         cmd_we = nxt.we; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata; cmd_wstrb = nxt.wstrb; cmd_valid = 1'b1;
      end
      for (int i = 0; i <= hold; i++) begin
         check("rsp_valid_hold", rsp_valid, 1'b1);
         check("rsp_we", rsp_we, t.we);
         check("rsp_rdata", rsp_rdata, exp_rd);
         check("rsp_resp", rsp_resp, t.resp);
         check("rsp_lat", rsp_lat, 64'(exp_lat(t)));
         check("cmd_ready_in_rsp", cmd_ready, 1'b0);
         check("busy_in_rsp", busy, 1'b1);
         if (i == hold) rsp_ready = 1'b1;
         @(negedge aclk);
      end
      rsp_ready = 1'b0;
      check("rsp_valid_drop", rsp_valid, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("cmd_ready_idle", cmd_ready, 1'b1);
      if (t.we) begin
         check("n_aw", n_aw, 1); check("n_w", n_w, 1); check("n_b", n_b, 1); check("n_ar", n_ar, 0);
         check("awvalid_cycles", cyc_awv, t.daw + 1);
         check("wvalid_cycles", cyc_wv, t.dw + 1);
         check("awaddr", cap_awaddr, t.addr);
         check("wdata", cap_wdata, t.wdata);
         check("wstrb", cap_wstrb, t.wstrb);
      end else begin
         check("n_ar", n_ar, 1); check("n_r", n_r, 1); check("n_aw", n_aw, 0); check("n_w", n_w, 0);
         check("arvalid_cycles", cyc_arv, t.dar + 1);
         check("araddr", cap_araddr, t.addr);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t, nxt, dummy;
      int   k;
      viol = 0;
      d_aw = 0; d_w = 0; d_b = 0; d_ar = 0; d_r = 0; s_resp = '0; s_rdata = '0;
      dummy = mk(0, '0, '0, '0, 0, 0, 0, 0, 0, RESP_OKAY, '0);

      @(negedge aclk); #1;
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_awvalid", axi.awvalid, 1'b0);
      check("rst_wvalid", axi.wvalid, 1'b0);
      check("rst_arvalid", axi.arvalid, 1'b0);
      check("rst_bready", axi.bready, 1'b0);
      check("rst_rready", axi.rready, 1'b0);
      check("rst_awaddr", axi.awaddr, 0);
      check("rst_wdata", axi.wdata, 0);
      check("rst_wstrb", axi.wstrb, 0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_lat", rsp_lat, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_cmd_ready", cmd_ready, 1'b1);

      // Directed: zero-wait write, delayed AW, delayed R, DECERR read, held response + back-to-back saturating read.
      t = mk(1, 32'h04, 32'h3, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY, '0);
      issue(t); collect(t, 0, 0, dummy);
      t = mk(1, 32'h08, 32'h1234_5678, 4'h5, 3, 0, 0, 0, 0, RESP_OKAY, '0);
      issue(t); collect(t, 0, 0, dummy);
      t = mk(0, 32'h10, '0, '0, 0, 0, 0, 0, 2, RESP_OKAY, 32'hDEAD_BEEF);
      issue(t); collect(t, 0, 0, dummy);
      t = mk(0, 32'hFFC, '0, '0, 0, 0, 0, 0, 0, RESP_DECERR, 32'h0BAD_0BAD);
      issue(t); collect(t, 0, 0, dummy);
      t   = mk(1, 32'h20, 32'hA5A5_5A5A, 4'hC, 1, 2, 1, 0, 0, RESP_SLVERR, '0);
      nxt = mk(0, 32'h24, '0, '0, 0, 0, 0, 0, 20, RESP_OKAY, 32'hCAFE_F00D);
      issue(t); collect(t, 5, 1, nxt);
      issue(nxt); collect(nxt, 0, 0, dummy);

      // Reset while waiting for the write response.
      t = mk(1, 32'h30, 32'h1111_2222, 4'hF, 0, 0, 10, 0, 0, RESP_OKAY, '0);
      issue(t);
      k = 0;
      while (axi.bready !== 1'b1 && k < 50) begin @(negedge aclk); k++; end
      check("bready_seen", axi.bready, 1'b1);
      areset = 1'b1;
      #1;
      check("mid_rst_awvalid", axi.awvalid, 1'b0);
      check("mid_rst_wvalid", axi.wvalid, 1'b0);
      check("mid_rst_bready", axi.bready, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b0);
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      repeat (2) @(negedge aclk);
      check("mid_rst_no_rsp", rsp_valid, 1'b0);
      t = mk(0, 32'h40, '0, '0, 1, 0, 0, 1, 1, RESP_OKAY, 32'h7654_3210);
      issue(t); collect(t, 0, 0, dummy);

      // Randomized run, with random response hold and back-to-back commands.
      t = gen();
      issue(t);
      for (int n = 0; n < 40; n++) begin
         bit bb;
         nxt = gen();
         bb  = 1'($urandom_range(0, 1));
         collect(t, $urandom_range(0, 3), bb, nxt);
         issue(nxt);
         t = nxt;
      end
      collect(t, 0, 0, dummy);

      check("protocol_violations", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4lite_master_adapter.md
Name: axi4lite_master_adapter

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions. It lets local sequencers, DMA-lite engines and bring-up controllers drive our AXI4-Lite peripheral slaves (timer, GPIO, etc.) over the shared interconnect. It also reports per-transaction latency for debug.

Parameters:
ADDR_WIDTH, 32, AXI and command address width
DATA_WIDTH, 32, AXI and command data width (32 or 64)
LAT_WIDTH, 8, width of saturating latency counter
AXI_PROT, 3'b000, constant driven on awprot/arprot

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&&ready
rsp_we  out  1  echo of cmd_we
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  bresp/rresp
rsp_lat  out  LAT_WIDTH  cycles from first AXI valid to B/R handshake, saturating
busy  out  1  state != IDLE
m_axi_awaddr/awprot/awvalid, awready  out/out/out, in  ADDR_WIDTH/3/1, 1  write address channel
m_axi_wdata/wstrb/wvalid, wready  out/out/out, in  DATA_WIDTH/DATA_WIDTH/8/1, 1  write data channel
m_axi_bresp, bvalid in; bready out  2/1/1  write response channel
m_axi_araddr/arprot/arvalid, arready  out/out/out, in  ADDR_WIDTH/3/1, 1  read address channel
m_axi_rdata/rresp/rvalid in; rready out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync release on aclk): state=IDLE; all *valid, bready, rready, rsp_valid = 0. Address, data and strobe outputs = 0. rsp_* = 0, rsp_lat = 0. cmd_ready = 0 while areset is high.
- cmd_ready = (state==IDLE) && !areset. Combinational from the state register only; no dependence on cmd_valid.
- States: IDLE, WR (AW/W in flight), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: on cmd accept, register addr/wdata/wstrb/we.
  - Write: next cycle awvalid=1 and wvalid=1 together; -> WR.
  - Read: next cycle arvalid=1; -> RD_ADDR.
- WR: aw_done and w_done flags are tracked independently.
  - awvalid drops the cycle after the awready handshake; wvalid drops the cycle after the wready handshake.
  - Neither channel waits for the other.
  - When both are done (including same-cycle handshakes) -> WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready, capture bresp, bready=0, rsp_rdata=0 -> RSP.
- RD_ADDR: on arready, arvalid=0, rready=1 -> RD_DATA.
- RD_DATA: on rvalid&&rready, capture rdata and rresp, rready=0 -> RSP.
- RSP: rsp_valid=1; rsp_* held stable until rsp_ready, then -> IDLE. Next command can be accepted the following cycle.
- bready/rready are never asserted outside WR_RESP/RD_DATA.
- AXI payload is stable while the corresponding valid is high. valid is never withdrawn before its handshake.
- rsp_lat: cleared when the first AXI valid asserts; increments each cycle until the B/R handshake cycle (inclusive); saturates at 2^LAT_WIDTH-1. Zero-wait slave read = 2 (AR cycle + R cycle).
- Error responses (SLVERR/DECERR) are passed through unchanged; no retry.
- areset mid-transaction: all valids/readies drop immediately; the transaction is abandoned with no response. The interconnect is reset together with this block.
- Throughput: one transaction outstanding. Minimum write period is 4 cycles, minimum read period is 4 cycles.

Decomposition:
- axi4lite_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - state enum typedef axi4lite_mst_state_e
- No sub-module. The FSM, channel flags and latency counter are one always_ff block plus one output-decode block.

Test Plan:
- Write cmd addr=0x04, wdata=0x0000_0003, wstrb=0xF; slave awready/wready/bvalid immediate -> awvalid&wvalid high 1 cycle, rsp_valid with rsp_resp=00, rsp_lat=2.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, single response, rsp_lat=5.
- Read addr=0x10; slave returns rdata=0xDEAD_BEEF with 2-cycle rvalid delay -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_we=0, rsp_lat=4.
- Read to unmapped 0xFFC with rresp=DECERR -> rsp_resp=2'b11, no retry, busy returns to 0 after rsp_ready.
- rsp_ready held low 5 cycles, then back-to-back cmd_valid -> cmd_ready=0 until RSP drains, rsp_* stable throughout; LAT_WIDTH=4 with 20-cycle slave stall -> rsp_lat=15.
- areset asserted while in WR_RESP -> awvalid/wvalid/bready/rsp_valid=0 in the same cycle; after release, new read completes normally.
